// File: rtl/cfd_hit_extractor_pkg.sv
// cfd_hit_extractor_pkg
// Width helpers, pipeline latency and sample conversion shared by the CFD hit extractor.
//   cor_bits / inv_bits / sum_bits / lr_bits : datapath widths derived from the parameters
//   latency                                  : input group to FIFO write, in cycles
//   offset_to_signed                         : offset-binary sample to signed integer
package cfd_hit_extractor_pkg;

    // Corrected sample: baseline-sum width plus a guard bit for the subtraction.
    function automatic int unsigned cor_bits(input int unsigned bsumbits);
        return bsumbits + 1;
    endfunction

    // Inverted branch carries the extra gain bits.
    function automatic int unsigned inv_bits(input int unsigned bsumbits,
                                             input int unsigned shift);
        return cor_bits(bsumbits) + shift;
    endfunction

    function automatic int unsigned sum_bits(input int unsigned bsumbits,
                                             input int unsigned shift);
        return inv_bits(bsumbits, shift) + 1;
    endfunction

    // Bisection accumulates L+R before halving, so one more bit than the sums.
    function automatic int unsigned lr_bits(input int unsigned bsumbits,
                                            input int unsigned shift);
        return sum_bits(bsumbits, shift) + 1;
    endfunction

    // Three cycles to registered sums, one decision cycle, one cycle per result bit.
    function automatic int unsigned latency(input int unsigned resolution);
        return 4 + resolution;
    endfunction

    // Flip the MSB and sign-extend the low 'bits' bits to a full int.
    function automatic int offset_to_signed(input logic [31:0] sample,
                                            input int unsigned bits);
        logic [31:0] flipped;
        flipped = sample ^ (32'd1 << (bits - 1));
        return $signed(flipped << (32 - bits)) >>> (32 - bits);
    endfunction

endpackage

// File: rtl/cfd_hit_extractor_if.sv
// cfd_hit_extractor_if
// Valid/ready result stream from the CFD hit extractor to the hit-record builder.
//   t_out   : {ltc, lane, subsample} at the FIFO head
//   t_valid : head is valid
//   t_ready : consumer takes the head when t_valid & t_ready
interface cfd_hit_extractor_if #(
    parameter int unsigned TBITS = 38
);
    logic [TBITS-1:0] t_out;
    logic             t_valid;
    logic             t_ready;

    modport master (output t_out, output t_valid, input t_ready);
    modport slave  (input t_out, input t_valid, output t_ready);
endinterface

// File: rtl/cfd_hit_extractor_bisect_stage.sv
// cfd_hit_extractor_bisect_stage
// One registered bisection step of the zero-crossing interval [L, R].
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_l, i_r         : interval ends (L >= 0 > R on entry)
//   i_word           : result bits so far
//   o_l, o_r, o_word : narrowed interval and word with one more bit appended at the LSB
module cfd_hit_extractor_bisect_stage #(
    parameter int unsigned LRBITS     = 23,
    parameter int unsigned RESOLUTION = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic signed [LRBITS-1:0] i_l,
    input  logic signed [LRBITS-1:0] i_r,
    input  logic [RESOLUTION-1:0]    i_word,
    output logic signed [LRBITS-1:0] o_l,
    output logic signed [LRBITS-1:0] o_r,
    output logic [RESOLUTION-1:0]    o_word
);
    logic signed [LRBITS-1:0] w_mid;
    logic signed [LRBITS-1:0] w_half;
    logic                     w_bit;

    logic signed [LRBITS-1:0] r_l;
    logic signed [LRBITS-1:0] r_r;
    logic [RESOLUTION-1:0]    r_word;

    // m = L + R is twice the midpoint; its sign says which half holds the crossing.
    always_comb begin
        w_mid  = i_l + i_r;
        w_half = w_mid >>> 1;
        w_bit  = ~w_mid[LRBITS-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_l    <= '0;
            r_r    <= '0;
            r_word <= '0;
        end else begin
            r_l    <= w_bit ? w_half : i_l;
            r_r    <= w_bit ? i_r : w_half;
            r_word <= (i_word << 1) | RESOLUTION'(w_bit);
        end
    end

    assign o_l    = r_l;
    assign o_r    = r_r;
    assign o_word = r_word;
endmodule

// File: rtl/cfd_hit_extractor.sv
// cfd_hit_extractor
// Constant-fraction time extractor for NSAMP-samples-per-clock digitizer streams.
// Baseline-corrects each group, forms CFD sums, picks the earliest TOT-gated zero crossing,
// bisects it to RESOLUTION sub-sample bits and queues {ltc, lane, subsample} in a small FIFO.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : detection enable (in-flight results still complete)
//   i_ltc          : time counter of the current group
//   i_samples      : NSAMP offset-binary samples, sample 0 (earliest) in the low bits
//   i_tot          : per-sample TOT flags
//   i_bsum         : baseline sum, two's complement, scaled by 2^(BSUMBITS-INBITS)
//   io_hit         : result stream (t_out / t_valid / t_ready)
//   o_drop_count   : saturating count of results lost to a full FIFO
module cfd_hit_extractor
    import cfd_hit_extractor_pkg::*;
#(
    parameter int unsigned INBITS     = 14,
    parameter int unsigned BSUMBITS   = 18,
    parameter int unsigned NSAMP      = 4,
    parameter int unsigned DELAY      = 1,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned RESOLUTION = 4,
    parameter int unsigned HOLDOFF    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [31:0]             i_ltc,
    input  logic [NSAMP*INBITS-1:0] i_samples,
    input  logic [NSAMP-1:0]        i_tot,
    input  logic [BSUMBITS-1:0]     i_bsum,
    cfd_hit_extractor_if.master     io_hit,
    output logic [15:0]             o_drop_count
);
    localparam int unsigned IDXBITS = $clog2(NSAMP);
    localparam int unsigned SCALE   = BSUMBITS - INBITS;
    localparam int unsigned CORBITS = cor_bits(BSUMBITS);
    localparam int unsigned INVBITS = inv_bits(BSUMBITS, SHIFT);
    localparam int unsigned SUMBITS = sum_bits(BSUMBITS, SHIFT);
    localparam int unsigned LRBITS  = lr_bits(BSUMBITS, SHIFT);
    localparam int unsigned TBITS   = 32 + IDXBITS + RESOLUTION;
    localparam int unsigned PTRBITS = $clog2(FIFO_DEPTH);
    localparam int unsigned HOBITS  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    // Input group to registered sums.
    localparam int unsigned SUMDLY  = 3;

    // ------------------------------------------------------------------------------------
    // Correction, records and CFD sums
    // ------------------------------------------------------------------------------------
    logic signed [CORBITS-1:0] w_cor     [NSAMP];
    logic signed [CORBITS-1:0] r_cor_rec [2*NSAMP];
    logic signed [INVBITS-1:0] r_inv_rec [2*NSAMP];
    logic signed [SUMBITS-1:0] r_sum     [NSAMP+1];
    logic [NSAMP-1:0]          r_tot_d   [SUMDLY];
    logic [31:0]               r_ltc_d   [SUMDLY];

    always_comb begin
        for (int k = 0; k < int'(NSAMP); k++) begin
            w_cor[k] = CORBITS'(offset_to_signed(32'(i_samples[k*INBITS +: INBITS]), INBITS)
                                <<< SCALE) - CORBITS'($signed(i_bsum));
        end
    end

    // r_cor_rec holds groups {G, G+1}; r_inv_rec is the inverted copy one group older,
    // {G-1, G}, so index k+NSAMP-DELAY lands DELAY samples before cor index k.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int j = 0; j < int'(2 * NSAMP); j++) begin
                r_cor_rec[j] <= '0;
                r_inv_rec[j] <= '0;
            end
            for (int k = 0; k <= int'(NSAMP); k++) begin
                r_sum[k] <= '0;
            end
            for (int d = 0; d < int'(SUMDLY); d++) begin
                r_tot_d[d] <= '0;
                r_ltc_d[d] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NSAMP); j++) begin
                r_cor_rec[j]         <= r_cor_rec[j+NSAMP];
                r_cor_rec[j+NSAMP]   <= w_cor[j];
            end
            for (int j = 0; j < int'(2 * NSAMP); j++) begin
                r_inv_rec[j] <= -(INVBITS'(r_cor_rec[j]) <<< SHIFT);
            end
            for (int k = 0; k <= int'(NSAMP); k++) begin
                r_sum[k] <= SUMBITS'(r_cor_rec[k]) + SUMBITS'(r_inv_rec[k+NSAMP-DELAY]);
            end
            r_tot_d[0] <= i_tot;
            r_ltc_d[0] <= i_ltc;
            for (int d = 1; d < int'(SUMDLY); d++) begin
                r_tot_d[d] <= r_tot_d[d-1];
                r_ltc_d[d] <= r_ltc_d[d-1];
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Crossing decision and holdoff
    // ------------------------------------------------------------------------------------
    logic                     w_hit;
    logic                     w_accept;
    logic [IDXBITS-1:0]       w_lane;
    logic signed [LRBITS-1:0] w_left;
    logic signed [LRBITS-1:0] w_right;

    logic                     r_dec_valid;
    logic [IDXBITS-1:0]       r_dec_lane;
    logic [31:0]              r_dec_ltc;
    logic signed [LRBITS-1:0] r_dec_l;
    logic signed [LRBITS-1:0] r_dec_r;
    logic [HOBITS-1:0]        r_holdoff;

    // Scan from the top lane down so the lowest qualifying lane is the one left standing.
    always_comb begin
        w_hit   = 1'b0;
        w_lane  = '0;
        w_left  = '0;
        w_right = '0;
        for (int i = int'(NSAMP) - 1; i >= 0; i--) begin
            if (r_tot_d[SUMDLY-1][i] && !r_sum[i][SUMBITS-1] && r_sum[i+1][SUMBITS-1]) begin
                w_hit   = 1'b1;
                w_lane  = IDXBITS'(i);
                w_left  = LRBITS'(r_sum[i]);
                w_right = LRBITS'(r_sum[i+1]);
            end
        end
        w_accept = w_hit && i_enable && (r_holdoff == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dec_valid <= 1'b0;
            r_dec_lane  <= '0;
            r_dec_ltc   <= '0;
            r_dec_l     <= '0;
            r_dec_r     <= '0;
            r_holdoff   <= '0;
        end else begin
            r_dec_valid <= w_accept;
            r_dec_lane  <= w_lane;
            r_dec_ltc   <= r_ltc_d[SUMDLY-1];
            r_dec_l     <= w_left;
            r_dec_r     <= w_right;
            if (w_accept) begin
                r_holdoff <= HOBITS'(HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - HOBITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Bisection pipeline with matching valid/lane/ltc delay line
    // ------------------------------------------------------------------------------------
    logic signed [LRBITS-1:0] w_l    [RESOLUTION+1];
    logic signed [LRBITS-1:0] w_r    [RESOLUTION+1];
    logic [RESOLUTION-1:0]    w_word [RESOLUTION+1];

    logic                     r_pv    [RESOLUTION];
    logic [IDXBITS-1:0]       r_plane [RESOLUTION];
    logic [31:0]              r_pltc  [RESOLUTION];

    assign w_l[0]    = r_dec_l;
    assign w_r[0]    = r_dec_r;
    assign w_word[0] = '0;

    for (genvar s = 0; s < RESOLUTION; s++) begin : g_stage
        cfd_hit_extractor_bisect_stage #(
            .LRBITS     (LRBITS),
            .RESOLUTION (RESOLUTION)
        ) u_stage (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_l     (w_l[s]),
            .i_r     (w_r[s]),
            .i_word  (w_word[s]),
            .o_l     (w_l[s+1]),
            .o_r     (w_r[s+1]),
            .o_word  (w_word[s+1])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < int'(RESOLUTION); s++) begin
                r_pv[s]    <= 1'b0;
                r_plane[s] <= '0;
                r_pltc[s]  <= '0;
            end
        end else begin
            r_pv[0]    <= r_dec_valid;
            r_plane[0] <= r_dec_lane;
            r_pltc[0]  <= r_dec_ltc;
            for (int s = 1; s < int'(RESOLUTION); s++) begin
                r_pv[s]    <= r_pv[s-1];
                r_plane[s] <= r_plane[s-1];
                r_pltc[s]  <= r_pltc[s-1];
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Output FIFO with drop accounting
    // ------------------------------------------------------------------------------------
    logic [TBITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTRBITS:0] r_wptr;
    logic [PTRBITS:0] r_rptr;
    logic [15:0]      r_drop_count;

    logic             w_wr;
    logic [TBITS-1:0] w_wdata;
    logic             w_empty;
    logic             w_full;
    logic             w_rd;
    logic             w_push;
    logic             w_drop;

    // Pointers carry an extra wrap bit: equal low bits with differing wrap bits means full.
    always_comb begin
        w_wr    = r_pv[RESOLUTION-1];
        w_wdata = {r_pltc[RESOLUTION-1], r_plane[RESOLUTION-1], w_word[RESOLUTION]};
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[PTRBITS] != r_rptr[PTRBITS]) &&
                  (r_wptr[PTRBITS-1:0] == r_rptr[PTRBITS-1:0]);
        w_rd    = !w_empty && io_hit.t_ready;
        // A read in the same cycle frees the slot, so a full FIFO can still accept.
        w_push  = w_wr && (!w_full || w_rd);
        w_drop  = w_wr && w_full && !w_rd;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int e = 0; e < int'(FIFO_DEPTH); e++) begin
                r_mem[e] <= '0;
            end
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PTRBITS-1:0]] <= w_wdata;
                r_wptr                     <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign io_hit.t_out   = r_mem[r_rptr[PTRBITS-1:0]];
    assign io_hit.t_valid = !w_empty;
    assign o_drop_count   = r_drop_count;
endmodule

// File: tb/tb_cfd_hit_extractor.sv
// tb_cfd_hit_extractor
// Directed bench: stimulus pushes hand-computed results into a scoreboard queue, a monitor
// pops and compares on every t_valid & t_ready handshake.
module tb_cfd_hit_extractor;
    localparam int unsigned INBITS = 14;
    localparam int unsigned NSAMP  = 4;
    localparam int unsigned TBITS  = 38;

    localparam logic [INBITS-1:0] BASE = 14'd8192;  // corrected value 0
    localparam logic [INBITS-1:0] HIGH = 14'd8292;  // corrected value 1600

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic [31:0]             ltc;
    logic [NSAMP*INBITS-1:0] samples;
    logic [NSAMP-1:0]        tot;
    logic [17:0]             bsum;
    logic [15:0]             drop_count;

    cfd_hit_extractor_if #(.TBITS(TBITS)) u_if ();

    cfd_hit_extractor u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_ltc        (ltc),
        .i_samples    (samples),
        .i_tot        (tot),
        .i_bsum       (bsum),
        .io_hit       (u_if),
        .o_drop_count (drop_count)
    );

    always #5 clk = ~clk;

    logic [TBITS-1:0] exp_q[$];
    logic [TBITS-1:0] want;
    logic [31:0]      ltc_ctr = 32'h0001_0000;
    int               n_checks = 0;
    int               n_fail = 0;

    // Monitor: every accepted head must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && u_if.t_valid && u_if.t_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got %h, required none", u_if.t_out);
            end else begin
                want = exp_q.pop_front();
                if (u_if.t_out !== want) begin
                    n_fail++;
                    $display("FAIL result: got %h, required %h", u_if.t_out, want);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Present one group for one cycle; returns one cycle later at posedge + 1.
    task automatic present(input logic [INBITS-1:0] s0, input logic [INBITS-1:0] s1,
                           input logic [INBITS-1:0] s2, input logic [INBITS-1:0] s3,
                           input logic [NSAMP-1:0] t);
        samples = {s3, s2, s1, s0};
        tot     = t;
        ltc     = ltc_ctr;
        @(posedge clk);
        #1;
        ltc_ctr = ltc_ctr + 32'd1;
    endtask

    task automatic idle(input int n, input logic [INBITS-1:0] v);
        repeat (n) present(v, v, v, v, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        tot          = '0;
        bsum         = '0;
        ltc          = '0;
        samples      = {BASE, BASE, BASE, BASE};
        u_if.t_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_t_valid", 64'(u_if.t_valid), 64'd0);
        check("reset_t_out", 64'(u_if.t_out), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);

        // Single pulse on lane 1, later samples stay high: L=1600, R=-4800 -> 0100.
        idle(4, BASE);
        exp_q.push_back({ltc_ctr, 2'd1, 4'b0100});
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        idle(7, HIGH);
        check("latency_not_yet", 64'(u_if.t_valid), 64'd0);
        idle(1, HIGH);
        check("latency_valid", 64'(u_if.t_valid), 64'd1);
        idle(10, HIGH);
        check("single_pulse_drained", 64'(exp_q.size()), 64'd0);
        idle(4, BASE);

        // Same pulse without TOT: nothing.
        present(BASE, HIGH, HIGH, HIGH, 4'b0000);
        idle(12, HIGH);
        check("no_tot_drop_count", 64'(drop_count), 64'd0);
        check("no_tot_t_valid", 64'(u_if.t_valid), 64'd0);
        idle(4, BASE);

        // Crossings in lanes 0 and 2: lane 0 wins, L=1600, R=-6400 -> 0011.
        exp_q.push_back({ltc_ctr, 2'd0, 4'b0011});
        present(HIGH, BASE, HIGH, BASE, 4'b0101);
        idle(12, BASE);
        check("lowest_lane_drained", 64'(exp_q.size()), 64'd0);

        // Holdoff: crossings in L, L+1, L+3 -> results for L and L+3 only.
        exp_q.push_back({ltc_ctr, 2'd1, 4'b0100});
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        present(BASE, HIGH, HIGH, HIGH, 4'b0000);
        exp_q.push_back({ltc_ctr, 2'd1, 4'b0100});
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        idle(12, BASE);
        check("holdoff_drained", 64'(exp_q.size()), 64'd0);

        // Detection disabled: qualifying crossing is ignored.
        enable = 1'b0;
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        idle(10, BASE);
        enable = 1'b1;
        check("disabled_t_valid", 64'(u_if.t_valid), 64'd0);
        idle(2, BASE);

        // FIFO full: five crossings with t_ready low, fifth is dropped.
        u_if.t_ready = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if ((k % 3 == 0) && (k < 12)) exp_q.push_back({ltc_ctr, 2'd1, 4'b0100});
            present(BASE, HIGH, HIGH, HIGH, (k % 3 == 0) ? 4'b0010 : 4'b0000);
        end
        idle(12, BASE);
        check("full_drop_count", 64'(drop_count), 64'd1);
        check("full_t_valid", 64'(u_if.t_valid), 64'd1);
        check("full_queued", 64'(exp_q.size()), 64'd4);
        check("full_head", 64'(u_if.t_out), 64'(exp_q[0]));
        idle(2, BASE);
        check("full_head_stable", 64'(u_if.t_out), 64'(exp_q[0]));
        u_if.t_ready = 1'b1;
        idle(3, BASE);
        check("drain_third_cycle_valid", 64'(u_if.t_valid), 64'd1);
        idle(1, BASE);
        check("drain_fourth_cycle_empty", 64'(u_if.t_valid), 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset two cycles after a crossing group discards it and clears drop_count.
        present(BASE, HIGH, HIGH, HIGH, 4'b0010);
        idle(1, HIGH);
        reset = 1'b1;
        idle(1, HIGH);
        reset = 1'b0;
        check("post_reset_t_valid", 64'(u_if.t_valid), 64'd0);
        check("post_reset_t_out", 64'(u_if.t_out), 64'd0);
        check("post_reset_drop_count", 64'(drop_count), 64'd0);
        idle(12, BASE);
        check("post_reset_no_result", 64'(u_if.t_valid), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cfd_hit_extractor.md
# cfd_hit_extractor

Parametrised constant-fraction time extractor for multi-sample-per-clock digitizer streams. Baseline-corrects NSAMP samples per clock, forms the CFD sum, finds the earliest TOT-gated zero crossing per group and bisects it to RESOLUTION sub-sample bits. Adds a re-trigger holdoff and a valid/ready output FIFO with drop accounting. Sits between the baseline estimator/TOT discriminator and the hit-record builder.

## Interface
- INBITS, 14, sample width, offset binary
- BSUMBITS, 18, baseline sum width, two's complement, scaled by 2^(BSUMBITS-INBITS)
- NSAMP, 4, samples per clock; power of two, 2..8; IDXBITS = log2(NSAMP)
- DELAY, 1, CFD delay in samples, 1..NSAMP
- SHIFT, 2, inverted branch gain 2^SHIFT
- RESOLUTION, 4, sub-sample bits, ≥1
- HOLDOFF, 2, cycles after an accepted crossing during which detection is suppressed; 0 disables
- FIFO_DEPTH, 4, output FIFO entries, power of two ≥2
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  detection enable
- ltc  in  32  time counter for the current group
- samples_in  in  NSAMP*INBITS  sample k at bits [(k+1)*INBITS-1 : k*INBITS]; sample 0 earliest
- tot_in  in  NSAMP  per-sample TOT flag
- bsum_in  in  BSUMBITS  baseline sum
- t_out  out  32+IDXBITS+RESOLUTION  {ltc, lane, subsample}; FIFO head
- t_valid  out  1  FIFO non-empty
- t_ready  in  1  consumer accepts head when t_valid & t_ready
- drop_count  out  16  saturating count of results lost to a full FIFO

## Operation
- Correction: flip sample MSB (offset→signed), shift left BSUMBITS-INBITS, sign-extend to CORBITS=BSUMBITS+1, subtract sign-extended bsum_in.
- Records: last 2*NSAMP corrected samples; parallel record of inverted samples -(cor<<SHIFT), INVBITS=CORBITS+SHIFT, one group older.
- CFD sums s[k], k=0..NSAMP: cor[k] + inv[k+NSAMP-DELAY], sign-extended to SUMBITS=INVBITS+1, registered.
- Crossing at lane i: tot (aligned) set, s[i] ≥ 0, s[i+1] < 0. Multiple lanes qualify → lowest lane wins. Lane NSAMP-1 uses s[NSAMP] (first sample of next group).
- Detection qualified by enable and holdoff counter == 0. Accepted crossing loads counter with HOLDOFF; counter decrements per cycle to 0.
- Bisection, per stage: m = L+R (LRBITS=SUMBITS+1). m<0 → bit 0, R ← m>>>1. Else bit 1, L ← m>>>1. MSB first.
- Result ltc field = ltc presented with the group containing the left sample; lane = i.
- FIFO: write on bisection completion. Full without simultaneous read → drop result, drop_count += 1 (saturate at 65535). Full with simultaneous read → write accepted.
- enable low: no new detections; in-flight results complete; FIFO keeps draining.

## Timing
- LATENCY = 4+RESOLUTION: 3 cycles to registered sums (tot delayed 3 to align), 1 crossing decision, RESOLUTION bisection.
- FIFO write at LATENCY after left sample's group; t_valid rises next cycle if FIFO was empty.
- Throughput: one result per cycle, fully pipelined.
- Reset (any cycle): records, sums, pipeline, holdoff, FIFO, drop_count cleared; cycle after reset: t_valid=0, t_out=0, drop_count=0; in-flight results discarded.
- t_out stable while t_valid & !t_ready.

## Structure
- Package cfd_pkg: width helpers (CORBITS, INVBITS, SUMBITS, LRBITS), LATENCY, offset-to-signed function.
- Sub-module cfd_bisect_stage (one L/R/word stage, generated RESOLUTION times); existing delay module reused for tot/lane/valid alignment.
- FIFO inline (small register array, pointers with extra wrap bit).

## Test plan
- Defaults, bsum_in=0, baseline samples 8192, lane 1 of group ltc=L is 8292 with all later samples 8292, tot on lane 1 → single result {L, 2'd1, 4'b0100} (left=1600, right=-4800).
- Same pulse, tot_in=0 → no result, drop_count=0.
- Qualifying crossings in lanes 0 and 2 of one group → one result, lane 0.
- HOLDOFF=2, crossings in groups L, L+1, L+3 → results for L and L+3 only.
- t_ready=0, FIFO_DEPTH=4, 5 crossings in separate groups → 4 queued in order, drop_count=1; then t_ready=1 drains 4 in 4 cycles.
- reset asserted 2 cycles after crossing group → no result, t_valid=0, drop_count=0.
